// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared types and constants for the UART transmit buffer.
//             Holds the transmit FSM state encoding, the number of data bits
//             per frame and the default bit period in clocks.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    localparam int DATA_BITS            = 8;
    // 100 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // PARITY is always part of the encoding so the state width does not
    // change between builds; it is only reachable with UART_TX_PARITY_EN.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Circular byte buffer feeding the UART serialiser.
//             A push is accepted when not full, or when a pop happens in the
//             same cycle. A push that is refused sets a sticky overflow flag.
//  Ports    : clock, reset     - system clock, synchronous active-high reset
//             pushReq/pushData - write strobe and byte
//             popReq           - remove head entry (ignored when empty)
//             headData         - current head entry
//             fifoFull/Empty   - count == DEPTH / count == 0
//             overflow         - sticky dropped-push indicator
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pushReq,
    input  logic [DATA_BITS-1:0] pushData,
    input  logic                 popReq,
    output logic [DATA_BITS-1:0] headData,
    output logic                 fifoFull,
    output logic                 fifoEmpty,
    output logic                 overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;

    logic w_popAcc;
    logic w_pushAcc;

    // Pops are judged against the registered empty flag, so a byte written
    // into an empty buffer only becomes visible on the following cycle.
    assign w_popAcc  = popReq && !fifoEmpty;
    assign w_pushAcc = pushReq && (!fifoFull || w_popAcc);

    assign fifoFull  = (r_count == c_CNT_W'(DEPTH));
    assign fifoEmpty = (r_count == '0);
    assign overflow  = r_overflow;
    assign headData  = r_mem[r_rdPtr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_popAcc) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            if (w_pushAcc && !w_popAcc) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_popAcc && !w_pushAcc) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (pushReq && !w_pushAcc) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only entries between the pointers are read.
    always_ff @(posedge clock) begin
        if (w_pushAcc) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffer
//  Purpose  : Buffered UART transmitter for the debug unit. Bytes pushed with
//             writeFifoFlag are queued and sent LSB-first as 8N1 frames.
//             uartDataSent pulses on the last clock of each stop bit.
//             holdTx blocks new frames but never truncates one in progress.
//  Ports    : clock, reset    - system clock, synchronous active-high reset
//             writeFifoFlag   - push dataIn this cycle
//             dataIn          - byte to transmit
//             holdTx          - suppress frame starts while high
//             txLine          - serial output, idle high
//             uartDataSent    - one-cycle completion pulse per byte
//             fifoFull/Empty  - buffer occupancy flags
//             overflow        - sticky dropped-push flag
//             txBusy          - a frame is in progress
//  Options  : UART_TX_PARITY_EN - insert an even-parity bit (8E1 framing)
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_buffer
    import uart_tx_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 writeFifoFlag,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 holdTx,
    output logic                 txLine,
    output logic                 uartDataSent,
    output logic                 fifoFull,
    output logic                 fifoEmpty,
    output logic                 overflow,
    output logic                 txBusy
);

    localparam int c_TICK_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_BITS);
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

    txState_t             r_state;
    txState_t             w_stateNext;
    logic [c_TICK_W-1:0]  r_tickCnt;
    logic [c_BIT_W-1:0]   r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_pop;
    logic                 w_bitEnd;
    logic                 w_txLine;
    logic                 w_dataSent;
    logic [DATA_BITS-1:0] w_headData;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .pushReq   (writeFifoFlag),
        .pushData  (dataIn),
        .popReq    (w_pop),
        .headData  (w_headData),
        .fifoFull  (fifoFull),
        .fifoEmpty (fifoEmpty),
        .overflow  (overflow)
    );

    assign w_bitEnd     = (r_tickCnt == c_TICK_MAX);
    assign txLine       = w_txLine;
    assign uartDataSent = w_dataSent;
    assign txBusy       = (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tickCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_stateNext;
            if (w_pop) begin
                r_shift   <= w_headData;
                r_tickCnt <= '0;
                r_bitIdx  <= '0;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^w_headData;
`endif
            end else if (r_state != IDLE) begin
                r_tickCnt <= w_bitEnd ? '0 : r_tickCnt + c_TICK_W'(1);
                if ((r_state == DATA) && w_bitEnd) begin
                    r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
                    r_bitIdx <= r_bitIdx + c_BIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        w_txLine    = 1'b1;
        w_dataSent  = 1'b0;
        case (r_state)
            IDLE: begin
                // holdTx only matters here, so a raised hold lets the
                // current frame run to its stop bit.
                if (!fifoEmpty && !holdTx) begin
                    w_pop       = 1'b1;
                    w_stateNext = START;
                end
            end
            START: begin
                w_txLine = 1'b0;
                if (w_bitEnd) begin
                    w_stateNext = DATA;
                end
            end
            DATA: begin
                w_txLine = r_shift[0];
                if (w_bitEnd && (r_bitIdx == c_BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    w_stateNext = PARITY;
`else
                    w_stateNext = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_txLine = r_parity;
                if (w_bitEnd) begin
                    w_stateNext = STOP;
                end
            end
`endif
            STOP: begin
                w_txLine = 1'b1;
                if (w_bitEnd) begin
                    w_dataSent  = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffer
//  Purpose  : Self-checking bench for uart_tx_buffer (DEPTH=4, CLKS_PER_BIT=4).
//             A transaction-level model (queue + frame-occupancy timer) runs
//             alongside the driver and pushes expected frames into a
//             scoreboard; a separate monitor decodes txLine and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic       writeFifoFlag;
    logic [7:0] dataIn;
    logic       holdTx;
    logic       txLine;
    logic       uartDataSent;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       overflow;
    logic       txBusy;

    uart_tx_buffer #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .writeFifoFlag (writeFifoFlag),
        .dataIn        (dataIn),
        .holdTx        (holdTx),
        .txLine        (txLine),
        .uartDataSent  (uartDataSent),
        .fifoFull      (fifoFull),
        .fifoEmpty     (fifoEmpty),
        .overflow      (overflow),
        .txBusy        (txBusy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic [7:0] mq[$];     // bytes held in the buffer
    exp_t       expq[$];   // scoreboard of frames yet to appear
    int         busy = 0;  // cycles of transmitter occupancy left
    bit         movf = 1'b0;
    bit         inFrame = 1'b0;

    // Evaluates what happens at the coming clock edge for the current inputs.
    task automatic modelStep();
        bit popNow;
        popNow = (busy == 0) && (mq.size() > 0) && !holdTx;
        if (popNow) begin
            exp_t e;
            e.data  = mq.pop_front();
            e.start = cyc + 1;    // line goes low right after the pop edge
            expq.push_back(e);
            busy = FRAME;
        end else if (busy > 0) begin
            busy--;
        end
        if (writeFifoFlag) begin
            if (mq.size() < DEPTH || popNow) mq.push_back(dataIn);
            else movf = 1'b1;
        end
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit hold);
        @(negedge clock);
        reset         = 1'b0;
        writeFifoFlag = wr;
        dataIn        = d;
        holdTx        = hold;
        modelStep();
    endtask

    task automatic rstCycle();
        @(negedge clock);
        reset         = 1'b1;
        writeFifoFlag = 1'b0;
        holdTx        = 1'b0;
        mq.delete();
        expq.delete();
        busy = 0;
        movf = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() > 0 || busy > 0 || expq.size() > 0 || inFrame) && n < 3000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain within bound", int'(n < 3000), 1);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int   sIdx;
        bit   haveExp;
        exp_t cur;
        int   samp [64];
        int   sent [64];
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                inFrame = 1'b0;
                chk("reset txLine", int'(txLine), 1);
                chk("reset txBusy", int'(txBusy), 0);
                chk("reset fifoEmpty", int'(fifoEmpty), 1);
                chk("reset fifoFull", int'(fifoFull), 0);
                chk("reset overflow", int'(overflow), 0);
                chk("reset uartDataSent", int'(uartDataSent), 0);
            end else begin
                chk("fifoFull", int'(fifoFull), int'(mq.size() == DEPTH));
                chk("fifoEmpty", int'(fifoEmpty), int'(mq.size() == 0));
                chk("overflow", int'(overflow), int'(movf));
                chk("txBusy", int'(txBusy), int'(busy > 0));
                if (!inFrame && txLine == 1'b0) begin
                    inFrame = 1'b1;
                    sIdx    = 0;
                    haveExp = (expq.size() > 0);
                    chk("frame expected", int'(haveExp), 1);
                    if (haveExp) begin
                        cur = expq.pop_front();
                        chk("frame start cycle", cyc, cur.start);
                    end
                end
                if (inFrame) begin
                    samp[sIdx] = int'(txLine);
                    sent[sIdx] = int'(uartDataSent);
                    sIdx++;
                    if (sIdx == FRAME) begin
                        inFrame = 1'b0;
                        if (haveExp) begin
                            int eb [12];
                            int nSent;
                            int lastSent;
                            eb[0] = 0;
                            for (int i = 0; i < 8; i++) eb[1+i] = int'(cur.data[i]);
                            if (NBITS == 11) eb[9] = int'(^cur.data);
                            eb[NBITS-1] = 1;
                            for (int k = 0; k < NBITS; k++) begin
                                int v;
                                v = eb[k];
                                for (int j = 0; j < CPB; j++)
                                    if (samp[k*CPB+j] != eb[k]) v = samp[k*CPB+j];
                                chk($sformatf("frame 0x%02h bit%0d", cur.data, k), v, eb[k]);
                            end
                            nSent    = 0;
                            lastSent = -1;
                            for (int j = 0; j < FRAME; j++)
                                if (sent[j] != 0) begin
                                    nSent++;
                                    lastSent = j;
                                end
                            chk($sformatf("frame 0x%02h sent pulses", cur.data), nSent, 1);
                            chk($sformatf("frame 0x%02h sent offset", cur.data), lastSent, FRAME - 1);
                        end
                    end
                end else begin
                    chk("uartDataSent outside frame", int'(uartDataSent), 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        bit hold;
        reset         = 1'b1;
        writeFifoFlag = 1'b0;
        dataIn        = 8'h00;
        holdTx        = 1'b0;
        rstCycle();
        rstCycle();

        // single byte
        step(1'b1, 8'hA5, 1'b0);
        drain();

        // overfill while held, then release
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("overflow after 5th push", int'(overflow), 1);
        drain();

        // push while full on the cycle the transmitter pops
        rstCycle();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b1);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("full+pop push keeps overflow low", int'(overflow), 0);
        drain();

        // hold raised mid-frame
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 8'h00, 1'b1);
        chk("held byte not started", int'(txBusy), 0);
        drain();

        // reset during data bit 3
        step(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b0);
        rstCycle();
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        drain();

        // parity-relevant byte
        step(1'b1, 8'h07, 1'b0);
        drain();

        // randomized traffic
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) hold = !hold;
            if (i == 300) rstCycle();
            else step(($urandom_range(0, 3) == 0), 8'($urandom), hold);
        end
        drain();

        chk("scoreboard empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
